seq_tx: RTL
===========

SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 Parameter WIDTH, default 12, frame length in bits.
REQ-002 Parameter PATTERN, default 4'b1011, 4-bit detect pattern; MSB is the oldest bit in time.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_i  input  WIDTH  parallel frame to serialise.
REQ-006 valid_i  input  1  frame request; qualified by ready_o.
REQ-007 ready_o  output  1  block can accept a frame.
REQ-008 x_o  output  1  serial bit stream, LSB of frame first; drives a sequence detector's x_i.
REQ-009 x_vld_o  output  1  x_o carries a frame bit this cycle.
REQ-010 exp_o  output  1  the last 4 emitted bits, including the current x_o, equal PATTERN (expected detect).
REQ-011 done_o  output  1  one-cycle end-of-frame pulse.
REQ-012 hits_o  output  $clog2(WIDTH+1)  PATTERN match count for the last frame; valid while done_o is high.

Function
REQ-013 FSM states are IDLE, SHIFT and DONE.
REQ-014 In IDLE, ready_o is 1 and x_o, x_vld_o, exp_o and done_o are 0.
REQ-015 A handshake occurs on a rising edge with valid_i && ready_o.
- data_i is captured into the shift register.
- Bit counter, 4-bit match window and hit counter clear.
- State moves to SHIFT.
REQ-016 The first bit (data_i[0]) appears on x_o in the cycle after the handshake edge, with x_vld_o=1.
REQ-017 In SHIFT, one bit is emitted per cycle, LSB first, for exactly WIDTH consecutive cycles.
- x_vld_o stays 1 throughout.
- ready_o is 0.
REQ-018 The match window shifts in each emitted bit.
- exp_o=1 in the same cycle as the bit that completes a PATTERN match.
- Matches overlap; the window never spans two frames, so no hit is possible before the 4th bit of a frame.
REQ-019 The hit counter increments once per exp_o cycle and saturates at WIDTH (cannot overflow by construction).
REQ-020 After the WIDTH-th bit, state moves to DONE for exactly one cycle.
- done_o=1 and hits_o holds the frame total.
- x_o=0, x_vld_o=0, ready_o=0.
REQ-021 From DONE, state returns to IDLE; the minimum frame period is WIDTH+2 cycles.
REQ-022 hits_o holds its value until the next handshake clears it.
REQ-023 valid_i and data_i are ignored while ready_o=0.
- No queuing.
- Changing data_i mid-frame does not alter the emitted bits.
REQ-024 No combinational path exists from any input to any output.

Reset
REQ-025 While reset=1 at a rising edge, the block enters IDLE.
- ready_o=1 after reset; x_o, x_vld_o, exp_o and done_o are 0; hits_o=0.
- Shift register, bit counter and match window clear.
REQ-026 Reset asserted mid-frame aborts the frame immediately.
- No done_o pulse is produced.
- No further bits are emitted.
REQ-027 A handshake in the cycle reset deasserts is accepted normally.

Structure
REQ-028 Package seq_pkg holds the FSM state enum (IDLE, SHIFT, DONE) and the default PATTERN constant.
REQ-029 Sub-module seq_match holds the 4-bit window and comparator, and produces exp_o.
- Ports: clk, reset, clr, bit_i, vld_i, match_o.
REQ-030 seq_tx holds the FSM, shift register, bit counter and hit counter.

Verification
REQ-031 data_i=12'b1110_1101_1011 -> x_o over 12 cycles is 1,1,0,1,1,0,1,1,0,1,1,1.
- exp_o is 1 on bits 4, 7 and 10 (0-based).
- done_o pulses with hits_o=3.
REQ-032 data_i=12'b1011_1011_1011 -> exp_o on bits 4 and 8; hits_o=2.
REQ-033 data_i=12'h000, then 12'hFFF -> exp_o never high; hits_o=0 for both frames.
REQ-034 valid_i held high continuously for two frames:
- ready_o drops during SHIFT and DONE.
- The second frame's first bit starts exactly WIDTH+2 cycles after the first frame's.
REQ-035 Reset pulsed during bit 6 of a frame:
- x_vld_o=0 next cycle and no done_o pulse.
- ready_o=1.
- The next frame's hits_o equals a golden software count.
REQ-036 Random frames (≥100) connected to a 1011 detector -> every det_o pulse matches exp_o after the detector's fixed latency.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// Holds the FSM state encoding and the default detect pattern.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // MSB is the oldest bit in time.
   localparam logic [3:0] DEF_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_tx_if.sv
// Frame request and serial-output bundle of seq_tx.
// The master modport is the frame source; the slave modport is the transmitter.
interface seq_tx_if #(
   parameter int WIDTH = 12
) ();

   localparam int HW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] data_i;
   logic             valid_i;
   logic             ready_o;
   logic             x_o;
   logic             x_vld_o;
   logic             exp_o;
   logic             done_o;
   logic [HW-1:0]    hits_o;

   modport master (
      output data_i, valid_i,
      input  ready_o, x_o, x_vld_o, exp_o, done_o, hits_o
   );

   modport slave (
      input  data_i, valid_i,
      output ready_o, x_o, x_vld_o, exp_o, done_o, hits_o
   );

endinterface

// File: rtl/seq_match.sv
// 4-bit sliding match window: match_o rises in the same cycle the completing bit
// appears downstream, because bit_i/vld_i are the next-cycle values of the stream.
module seq_match
   import seq_pkg::*;
#(
   parameter logic [3:0] PATTERN = DEF_PATTERN
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic bit_i,
   input  logic vld_i,
   output logic match_o
);

   logic [2:0] win_r;
   logic [2:0] fill_r;
   logic [2:0] base_win_s;
   logic [2:0] base_fill_s;
   logic [3:0] cand_s;
   logic [2:0] win_s;
   logic [2:0] fill_s;
   logic       match_s;

   // Next window/fill state; fill tracks how many of the three older slots hold frame bits.
   always_comb begin
      base_win_s  = clr ? 3'b000 : win_r;
      base_fill_s = clr ? 3'b000 : fill_r;
      cand_s      = {base_win_s, bit_i};
      win_s       = base_win_s;
      fill_s      = base_fill_s;
      match_s     = 1'b0;
      if (vld_i) begin
         win_s   = cand_s[2:0];
         fill_s  = {base_fill_s[1:0], 1'b1};
         match_s = (base_fill_s == 3'b111) && (cand_s == PATTERN);
      end else begin
         match_s = 1'b0;
      end
   end

   // Window and registered match flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         win_r   <= 3'b000;
         fill_r  <= 3'b000;
         match_o <= 1'b0;
      end else begin
         win_r   <= win_s;
         fill_r  <= fill_s;
         match_o <= match_s;
      end
   end

endmodule

// File: rtl/seq_tx.sv
// Parallel-to-serial frame transmitter that also predicts, per emitted bit,
// whether a downstream PATTERN detector fires, and counts those hits per frame.
module seq_tx
   import seq_pkg::*;
#(
   parameter int         WIDTH   = 12,
   parameter logic [3:0] PATTERN = DEF_PATTERN
) (
   input  logic    clk,
   input  logic    reset,
   seq_tx_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state_r, state_s;
   logic [WIDTH-1:0] sh_r, sh_s;
   logic [CW-1:0]    cnt_r, cnt_s;
   logic [CW-1:0]    hits_r, hits_s;
   logic             x_r, x_s;
   logic             x_vld_r, x_vld_s;
   logic             done_r, done_s;
   logic             ready_r, ready_s;
   logic             hs_s;
   logic             match_s;

   // Next state and next values of every registered output.
   always_comb begin
      state_s = state_r;
      sh_s    = sh_r;
      cnt_s   = cnt_r;
      hits_s  = hits_r;
      x_s     = 1'b0;
      x_vld_s = 1'b0;
      done_s  = 1'b0;
      ready_s = 1'b0;
      hs_s    = bus.valid_i && ready_r;

      if (match_s && (hits_r != CW'(WIDTH))) begin
         hits_s = hits_r + CW'(1);
      end else begin
         hits_s = hits_r;
      end

      case (state_r)
         IDLE: begin
            if (hs_s) begin
               x_s     = bus.data_i[0];
               x_vld_s = 1'b1;
               sh_s    = {1'b0, bus.data_i[WIDTH-1:1]};
               cnt_s   = CW'(1);
               hits_s  = '0;
               state_s = SHIFT;
            end else begin
               ready_s = 1'b1;
            end
         end
         SHIFT: begin
            // cnt_r counts bits already on x_o, so WIDTH means the frame is out.
            if (cnt_r == CW'(WIDTH)) begin
               done_s  = 1'b1;
               state_s = DONE;
            end else begin
               x_s     = sh_r[0];
               x_vld_s = 1'b1;
               sh_s    = {1'b0, sh_r[WIDTH-1:1]};
               cnt_s   = cnt_r + CW'(1);
            end
         end
         DONE: begin
            ready_s = 1'b1;
            state_s = IDLE;
         end
         default: begin
            ready_s = 1'b1;
            state_s = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         sh_r    <= '0;
         cnt_r   <= '0;
         hits_r  <= '0;
         x_r     <= 1'b0;
         x_vld_r <= 1'b0;
         done_r  <= 1'b0;
         ready_r <= 1'b1;
      end else begin
         state_r <= state_s;
         sh_r    <= sh_s;
         cnt_r   <= cnt_s;
         hits_r  <= hits_s;
         x_r     <= x_s;
         x_vld_r <= x_vld_s;
         done_r  <= done_s;
         ready_r <= ready_s;
      end
   end

   seq_match #(.PATTERN(PATTERN)) u_match (
      .clk     (clk),
      .reset   (reset),
      .clr     (hs_s),
      .bit_i   (x_s),
      .vld_i   (x_vld_s),
      .match_o (match_s)
   );

   assign bus.ready_o = ready_r;
   assign bus.x_o     = x_r;
   assign bus.x_vld_o = x_vld_r;
   assign bus.exp_o   = match_s;
   assign bus.done_o  = done_r;
   assign bus.hits_o  = hits_r;

endmodule
